orb_desc_scheduler: RTL
=======================

# orb_desc_scheduler

Parametrised keypoint scheduler and descriptor output buffer for the ORB pipeline. Gates corner pulses into the centroid/angle/rotation/generator chain using credit-based admission, tracks each admitted keypoint's coordinates in order, and pairs them with returning descriptors. Results are buffered in an output FIFO with a valid/ready handshake. It adds backpressure, coordinate tagging, flush and statistics that the single-slot `isFull` gating does not provide.

## Interface
Parameters:
- `DESC_BITS`, 256: descriptor width from the generator.
- `COORD_W`, 11: width of each keypoint coordinate.
- `MAX_INFLIGHT`, 4: keypoints allowed inside the chain at once; power of 2, at least 2.
- `OUT_DEPTH`, 4: output FIFO entries; power of 2, at least `MAX_INFLIGHT`.
- `CNT_W`, 16: statistics counter width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `ena` in 1: pipeline enable.
- `isCorner` in 1: corner pulse for the current window column.
- `corner_x`, `corner_y` in `COORD_W`: keypoint coordinates, sampled with `isCorner`.
- `gen_valid` in 1: generator descriptor strobe.
- `gen_desc` in `DESC_BITS`: generator descriptor.
- `flush` in 1: drain request, single-cycle pulse.
- `out_ready` in 1: consumer ready.
- `accept` out 1: corner admitted; drives the centroid corner input.
- `out_valid` out 1: output FIFO head is valid.
- `out_desc` out `DESC_BITS`: head descriptor.
- `out_x`, `out_y` out `COORD_W`: head coordinates.
- `busy` out 1: in-flight count nonzero or FIFO nonempty.
- `flush_done` out 1: one-cycle pulse when a drain completes.
- `err` out 1: sticky orphan-descriptor flag.
- `drop_cnt`, `accept_cnt` out `CNT_W`: statistics counters.

## Operation
- `inflight` counter: 0..`MAX_INFLIGHT`.
- Tag FIFO: depth `MAX_INFLIGHT`, holds {x,y}.
- Output FIFO: depth `OUT_DEPTH`, holds {desc,x,y}, with `out_cnt` occupancy.
- `credit_ok` = (`inflight` < `MAX_INFLIGHT`) and (`inflight` + `out_cnt` < `OUT_DEPTH`).
- `accept` = `isCorner` & `ena` & `credit_ok` & (state == RUN). This is combinational.
- On accept: push {x,y} to the tag FIFO and increment `inflight`.
- `isCorner` & `ena` without accept counts as a drop.
- On `gen_valid` & `ena` with `inflight` > 0:
  - pop the tag FIFO and decrement `inflight`;
  - push {`gen_desc`, tag} into the output FIFO.
  - The credit rule guarantees this push never overflows.
- `gen_valid` & `ena` with `inflight` == 0: descriptor discarded, `err` set; `err` clears only on reset.
- Accept and `gen_valid` in the same cycle: both apply, and `inflight` is unchanged.
- Output pop: `out_valid` & `out_ready`. This is independent of `ena`.
  - Push and pop in the same cycle at `out_cnt` == `OUT_DEPTH` is legal.
  - Pop when empty does nothing.
- `ena` = 0:
  - no accept;
  - tag FIFO and `inflight` frozen;
  - `gen_valid` ignored;
  - output side still drains.
- State machine:
  - RUN → DRAIN on `flush`.
  - DRAIN: `accept` forced to 0; corners during DRAIN are counted as drops.
  - DRAIN → DONE when `inflight` == 0 and `out_cnt` == 0.
  - DONE → RUN after one cycle; `flush_done` = 1 only in DONE.
  - `flush` while already in DRAIN or DONE is ignored.
- Pointers wrap modulo depth, with one extra bit for full/empty.

## Timing
- `accept` follows `isCorner` in the same cycle, with zero latency.
- `gen_valid` to `out_valid`: 1 cycle when the FIFO is empty, so the FIFO is not fall-through from input.
- `out_desc`/`out_x`/`out_y` are stable while `out_valid` & !`out_ready`.
- Reset values:
  - all counters, pointers, `err`, `out_valid`, `flush_done` = 0;
  - `busy` = 0; state RUN;
  - data outputs 0.
- Reset mid-operation discards all in-flight tags and buffered descriptors. Upstream blocks must share `rst`.

## Configuration
- `ORB_SCHED_STATS_EN`, defined: `drop_cnt` and `accept_cnt` increment and saturate at 2^`CNT_W`−1.
- Undefined: both outputs are tied to 0 and no counter flops are inferred. All other behaviour is identical.

## Structure
- Package `orb_pkg`:
  - default `DESC_BITS` and `COORD_W` constants;
  - state enum {RUN, DRAIN, DONE};
  - typedef `kp_tag_t` {x, y}.
- Sub-module `orb_sync_fifo` (parametrised width/depth, with count output), instantiated twice: once as the tag FIFO and once as the output FIFO.

## Test plan
- Single keypoint: `isCorner` with x=100, y=37; `gen_valid` 20 cycles later with desc=0xA5..A5 → `accept`=1 that cycle; next cycle `out_valid`=1, `out_x`=100, `out_y`=37, desc matches; `busy` falls after the pop.
- Credit limit (`MAX_INFLIGHT`=4, `out_ready`=0): 6 corners → first 4 accepted, 2 dropped.
  - `drop_cnt`=2 with the macro defined, 0 without.
  - After 4 `gen_valid`, new corners are still refused while `out_cnt`=4.
- Ordering: 3 corners at (1,1),(2,2),(3,3) and 3 descriptors D0..D2 → outputs arrive in order with matching coordinates under random `out_ready` stalls; each head holds while stalled.
- Orphan: `gen_valid` with `inflight`=0 → `err`=1 sticky, `out_valid` stays 0.
- Flush: 2 in flight, pulse `flush`, assert `isCorner` during DRAIN → no accept, `drop_cnt`+1; `flush_done` pulses exactly one cycle after the last output pop.
- Async reset: assert `rst`=0 mid-burst with `ena`=1 → all outputs 0 immediately, without waiting for a clock edge; a corner after release is accepted.

Source files
------------

// File: rtl/orb_pkg.sv
// Shared constants, FSM state encoding and keypoint tag type for the ORB descriptor scheduler.
package orb_pkg;

  localparam int unsigned ORB_DESC_BITS = 256;
  localparam int unsigned ORB_COORD_W   = 11;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } orb_state_e;

  typedef struct packed {
    logic [ORB_COORD_W-1:0] x;
    logic [ORB_COORD_W-1:0] y;
  } kp_tag_t;

endpackage

// File: rtl/orb_sync_fifo.sv
// Synchronous FIFO with extra-bit wrap pointers and occupancy count.
// The head output reads 0 when the FIFO is empty so reset clears all data outputs.
module orb_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, full, do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  // A pop frees the slot in the same cycle, so push at full is legal alongside a pop.
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign pop_data_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/orb_desc_scheduler.sv
// ORB keypoint scheduler: credit-gated corner admission, in-order coordinate tagging, descriptor output FIFO.
// Define ORB_SCHED_STATS_EN to enable the saturating drop/accept statistics counters.
module orb_desc_scheduler
  import orb_pkg::*;
#(
  parameter int unsigned DESC_BITS    = ORB_DESC_BITS,
  parameter int unsigned COORD_W      = ORB_COORD_W,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned OUT_DEPTH    = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 isCorner,
  input  logic [COORD_W-1:0]   corner_x,
  input  logic [COORD_W-1:0]   corner_y,
  input  logic                 gen_valid,
  input  logic [DESC_BITS-1:0] gen_desc,
  input  logic                 flush,
  input  logic                 out_ready,
  output logic                 accept,
  output logic                 out_valid,
  output logic [DESC_BITS-1:0] out_desc,
  output logic [COORD_W-1:0]   out_x,
  output logic [COORD_W-1:0]   out_y,
  output logic                 busy,
  output logic                 flush_done,
  output logic                 err,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [CNT_W-1:0]     accept_cnt
);

  localparam int unsigned IW = $clog2(MAX_INFLIGHT) + 1;
  localparam int unsigned OW = $clog2(OUT_DEPTH) + 1;
  localparam int unsigned SW = OW + 1;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } tag_t;

  typedef struct packed {
    logic [DESC_BITS-1:0] desc;
    tag_t                 tag;
  } out_entry_t;

  orb_state_e state_q, state_d;
  logic [IW-1:0] inflight;
  logic [OW-1:0] out_cnt;
  tag_t          tag_in, tag_head;
  out_entry_t    out_in, out_head;
  logic          credit_ok, gen_hit, orphan, out_pop;
  logic          err_q, flush_done_q;

  // Reserve an output slot for every keypoint in flight so returning descriptors never overflow.
  assign credit_ok = (inflight < IW'(MAX_INFLIGHT)) &&
                     ((SW'(inflight) + SW'(out_cnt)) < SW'(OUT_DEPTH));
  assign accept    = rst & isCorner & ena & credit_ok & (state_q == RUN);
  assign gen_hit   = gen_valid & ena & (inflight != '0);
  assign orphan    = gen_valid & ena & (inflight == '0);
  assign out_valid = (out_cnt != '0);
  assign out_pop   = out_valid & out_ready;

  assign tag_in = '{x: corner_x, y: corner_y};
  assign out_in = '{desc: gen_desc, tag: tag_head};

  orb_sync_fifo #(
    .WIDTH ($bits(tag_t)),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (accept),
    .push_data_i (tag_in),
    .pop_i       (gen_hit),
    .pop_data_o  (tag_head),
    .count_o     (inflight)
  );

  orb_sync_fifo #(
    .WIDTH ($bits(out_entry_t)),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (gen_hit),
    .push_data_i (out_in),
    .pop_i       (out_pop),
    .pop_data_o  (out_head),
    .count_o     (out_cnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush) state_d = DRAIN;
      DRAIN:   if ((inflight == '0) && (out_cnt == '0)) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= (state_d == DONE);
      if (orphan) err_q <= 1'b1;
    end
  end

  assign out_desc   = out_head.desc;
  assign out_x      = out_head.tag.x;
  assign out_y      = out_head.tag.y;
  assign busy       = (inflight != '0) || (out_cnt != '0);
  assign flush_done = flush_done_q;
  assign err        = err_q;

`ifdef ORB_SCHED_STATS_EN
  logic [CNT_W-1:0] drop_q, acc_q;
  logic             drop_ev;

  assign drop_ev = isCorner & ena & ~accept;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
      acc_q  <= '0;
    end else begin
      if (drop_ev && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
      if (accept && (acc_q != '1))   acc_q  <= acc_q + CNT_W'(1);
    end
  end

  assign drop_cnt   = drop_q;
  assign accept_cnt = acc_q;
`else
  assign drop_cnt   = '0;
  assign accept_cnt = '0;
`endif

endmodule
